draw_cmd_seq: RTL and testbench
===============================

# draw_cmd_seq

Command sequencer for the drawing circuit. Pops 32-bit display-list words from the DRAWCMD FIFO after a DRAWCTRL start, decodes SETFRAME / SETDRAWAREA / SETFCOLOR / PATBLT / NOP / EODL, and holds the frame, draw-area and colour state. For each PATBLT it computes a rectangle clipped to the draw area and frame, then hands it to the pattern-fill engine over a REQ/ACK handshake. It drives DRAWSTAT busy/error and the completion interrupt.

## Interface
- Parameters: none. Coordinate fields are 16 bit; clip arithmetic is 17 bit.
- ACLK  in  1  clock; single clock domain.
- ARESETN  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse when DRAWCTRL bit0 is written 1.
- CMD_DATA  in  32  head word of the first-word-fall-through command FIFO; valid when !CMD_EMPTY.
- CMD_EMPTY  in  1  FIFO empty.
- CMD_RDEN  out  1  pop the head word.
- PB_REQ  out  1  rectangle request to the fill engine.
- PB_ACK  in  1  engine accepts the request.
- PB_IDLE  in  1  engine has no work outstanding.
- PB_VRAMADR  out  32  frame base address.
- PB_STRIDE  out  16  frame width in pixels.
- PB_X, PB_Y  out  16 each  absolute origin of the clipped rectangle.
- PB_W, PB_H  out  16 each  clipped size, never 0 while PB_REQ is high.
- PB_COLOR  out  32  fill colour.
- BUSY  out  1  DRAWSTAT[0].
- ERR  out  1  sticky error: unknown opcode.
- ERR_OP  out  8  opcode that caused ERR.
- DRW_IRQ  out  1  one-cycle pulse at end of list.

## Operation
- Opcode is header bits [31:24]. Argument count per opcode:
  - 0x20 SETFRAME, 2 args: VRAMADR, then {FW, FH}.
  - 0x21 SETDRAWAREA, 2 args: {DAX, DAY}, then {DAW, DAH}.
  - 0x23 SETFCOLOR, 1 arg: COLOR.
  - 0x81 PATBLT, 2 args: {PX, PY}, then {PW, PH}.
  - 0x00 NOP, 0 args.
  - 0x0F EODL, 0 args.
  - Argument format {hi, lo} means hi = bits [31:16], lo = bits [15:0].
- States:
  - IDLE: START moves to FETCH, clears ERR and ERR_OP.
  - FETCH: pop the header. Unknown opcode moves to ERROR. EODL moves to DRAIN. NOP stays in FETCH. Any other opcode moves to ARG.
  - ARG: pop the argument words. After the last one, PATBLT moves to CLIP; all other opcodes move back to FETCH.
  - CLIP: compute the rectangle (one cycle). A non-empty result moves to ISSUE; an empty result moves to FETCH.
  - ISSUE: hold PB_REQ until PB_ACK, then move to FETCH.
  - DRAIN: wait for PB_IDLE, then move to DONE.
  - DONE: pulse DRW_IRQ, then move to IDLE.
  - ERROR: set ERR and ERR_OP, then move to IDLE with no IRQ.
- CMD_RDEN = (FETCH or ARG) and !CMD_EMPTY. A FIFO that goes empty mid-command stalls the FSM in place with no timeout.
- State registers update on the edge that pops their argument. SETFRAME, SETDRAWAREA and SETFCOLOR may change state while the engine is busy, because the engine captures all PB_* outputs at the handshake.
- Clip rules, all in 17-bit unsigned arithmetic:
  - Draw-area bounds: ax0 = min(DAX, FW), ax1 = min(DAX+DAW, FW).
  - Rectangle x start: x0 = ax0 + PX (PATBLT coordinates are relative to the draw-area origin).
  - Rectangle x end: x1 = min(x0+PW, ax1).
  - y is computed the same way using DAY, DAH, FH, PY and PH.
  - Empty when x0 >= x1 or y0 >= y1; no request is issued.
  - Otherwise PB_X = x0, PB_W = x1-x0, PB_Y = y0, PB_H = y1-y0.
- BUSY is high in every state except IDLE and ERROR. START while BUSY is ignored.

## Timing
- Reset values: every output is 0, and FSM, frame, area, colour and error registers are all cleared. Asserting ARESETN low mid-list aborts immediately and does not pulse the IRQ; the FIFO is not flushed.
- One word is consumed per cycle when the FIFO is non-empty. START at cycle t gives the first CMD_RDEN at t+1.
- The last PATBLT argument popped at cycle t gives CLIP at t+1 and PB_REQ at t+2.
- PB_REQ and all PB_* outputs stay stable while PB_REQ=1 and PB_ACK=0. A cycle where PB_REQ and PB_ACK are both high completes the handshake; PB_REQ drops the next cycle. The next header may be popped in that same next cycle.
- PB_ACK while PB_REQ=0 is ignored.
- PB_IDLE high in the DRAIN entry cycle gives DONE on the next cycle. DRW_IRQ is high for exactly one cycle. BUSY falls the cycle after DONE.

## Test plan
- Full fill: frame 0x20000000 640x480, area (0,0,640,480), colour 0xFF0000, PATBLT (0,0,640,480), EODL -> exactly one request with X=0, Y=0, W=640, H=480, COLOR=0x00FF0000, STRIDE=640; one DRW_IRQ; BUSY returns to 0.
- Area clip: area (160,120,320,240), PATBLT (0,0,640,480) -> X=160, Y=120, W=320, H=240.
- Edge clip: area full, PATBLT (480,360,320,240) -> X=480, Y=360, W=160, H=120.
- Empty and stall: PATBLT (700,0,10,10) in a full area gives no PB_REQ. Insert 20-cycle FIFO-empty gaps inside a command -> same result as without gaps. Hold PB_ACK low for 50 cycles -> PB_* outputs stay stable throughout.
- Errors and reset: opcode 0x55 -> ERR=1, ERR_OP=0x55, BUSY=0, no IRQ, and the next START clears ERR. ARESETN asserted in ISSUE -> all outputs 0 and no IRQ.

Source files
------------

// File: rtl/draw_cmd_seq.sv
// draw_cmd_seq -- display-list command sequencer for the drawing circuit.
//
// After a START pulse it pops 32-bit words from a first-word-fall-through
// command FIFO, decodes SETFRAME / SETDRAWAREA / SETFCOLOR / PATBLT / NOP /
// EODL, keeps the frame, draw-area and colour state, clips each PATBLT to the
// draw area and frame, and hands non-empty rectangles to the pattern-fill
// engine over a REQ/ACK handshake.
//
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   START                one-cycle start pulse (ignored while BUSY)
//   CMD_DATA/CMD_EMPTY   FIFO head word and empty flag
//   CMD_RDEN             pop the FIFO head word
//   PB_REQ/PB_ACK        rectangle request / accept to the fill engine
//   PB_IDLE              fill engine has no outstanding work
//   PB_VRAMADR/PB_STRIDE frame base address and width in pixels
//   PB_X/PB_Y/PB_W/PB_H  clipped rectangle (absolute origin, size)
//   PB_COLOR             fill colour
//   BUSY                 sequencer active
//   ERR/ERR_OP           sticky unknown-opcode flag and offending opcode
//   DRW_IRQ              one-cycle end-of-list pulse
module draw_cmd_seq (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        START,
  input  logic [31:0] CMD_DATA,
  input  logic        CMD_EMPTY,
  output logic        CMD_RDEN,
  output logic        PB_REQ,
  input  logic        PB_ACK,
  input  logic        PB_IDLE,
  output logic [31:0] PB_VRAMADR,
  output logic [15:0] PB_STRIDE,
  output logic [15:0] PB_X,
  output logic [15:0] PB_Y,
  output logic [15:0] PB_W,
  output logic [15:0] PB_H,
  output logic [31:0] PB_COLOR,
  output logic        BUSY,
  output logic        ERR,
  output logic [7:0]  ERR_OP,
  output logic        DRW_IRQ
);

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_EODL        = 8'h0F;
  localparam logic [7:0] OP_SETFRAME    = 8'h20;
  localparam logic [7:0] OP_SETDRAWAREA = 8'h21;
  localparam logic [7:0] OP_SETFCOLOR   = 8'h23;
  localparam logic [7:0] OP_PATBLT      = 8'h81;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ARG, S_CLIP, S_ISSUE, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  typedef struct packed {
    logic [16:0] lo;
    logic [16:0] hi;
  } span_t;

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic        arg_idx_q;       // 0 = first argument word, 1 = second
  logic [31:0] vram_q, color_q;
  logic [15:0] fw_q, fh_q;
  logic [15:0] dax_q, day_q, daw_q, dah_q;
  logic [15:0] px_q, py_q, pw_q, ph_q;
  logic [15:0] pb_x_q, pb_y_q, pb_w_q, pb_h_q;
  logic        err_q;
  logic [7:0]  err_op_q;

  logic        pop;
  logic        arg_last;
  logic [7:0]  hdr_op;
  span_t       span_x, span_y;
  logic        clip_empty;

  // One axis of the clip. lo + len can only overflow 17 bits when lo is
  // already past the area end, and that case is empty whatever hi becomes.
  function automatic span_t clip_axis(input logic [15:0] org, ext, lim, pos, len);
    logic [16:0] a0, a1, e, lo;
    span_t       r;
    a0   = (org < lim) ? {1'b0, org} : {1'b0, lim};
    e    = {1'b0, org} + {1'b0, ext};
    a1   = (e < {1'b0, lim}) ? e : {1'b0, lim};
    lo   = a0 + {1'b0, pos};
    e    = lo + {1'b0, len};
    r.lo = lo;
    r.hi = (e < a1) ? e : a1;
    return r;
  endfunction

  assign hdr_op     = CMD_DATA[31:24];
  assign pop        = ((state_q == S_FETCH) || (state_q == S_ARG)) && !CMD_EMPTY;
  assign arg_last   = (op_q == OP_SETFCOLOR) || arg_idx_q;
  assign span_x     = clip_axis(dax_q, daw_q, fw_q, px_q, pw_q);
  assign span_y     = clip_axis(day_q, dah_q, fh_q, py_q, ph_q);
  assign clip_empty = (span_x.lo >= span_x.hi) || (span_y.lo >= span_y.hi);

  // Next-state logic
  always_comb begin
    // NOTE: assign a default before the case so no path leaves state_d
    // unassigned; a missing default here infers a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (START) state_d = S_FETCH;
      S_FETCH: begin
        if (!CMD_EMPTY) begin
          unique case (hdr_op)
            OP_NOP:  state_d = S_FETCH;
            OP_EODL: state_d = S_DRAIN;
            OP_SETFRAME, OP_SETDRAWAREA, OP_SETFCOLOR, OP_PATBLT:
                     state_d = S_ARG;
            default: state_d = S_ERROR;
          endcase
        end
      end
      S_ARG:   if (!CMD_EMPTY && arg_last)
                 state_d = (op_q == OP_PATBLT) ? S_CLIP : S_FETCH;
      S_CLIP:  state_d = clip_empty ? S_FETCH : S_ISSUE;
      S_ISSUE: if (PB_ACK) state_d = S_FETCH;
      S_DRAIN: if (PB_IDLE) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register, command state and clipped-rectangle registers
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      arg_idx_q <= 1'b0;
      vram_q    <= '0;
      color_q   <= '0;
      fw_q      <= '0;
      fh_q      <= '0;
      dax_q     <= '0;
      day_q     <= '0;
      daw_q     <= '0;
      dah_q     <= '0;
      px_q      <= '0;
      py_q      <= '0;
      pw_q      <= '0;
      ph_q      <= '0;
      pb_x_q    <= '0;
      pb_y_q    <= '0;
      pb_w_q    <= '0;
      pb_h_q    <= '0;
      err_q     <= 1'b0;
      err_op_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout: every register here
      // samples pre-edge values, independent of statement order.
      state_q <= state_d;

      if (state_q == S_IDLE && START) begin
        err_q    <= 1'b0;
        err_op_q <= '0;
      end

      if (state_q == S_ERROR) begin
        err_q    <= 1'b1;
        err_op_q <= op_q;
      end

      if (pop && state_q == S_FETCH) begin
        op_q      <= hdr_op;
        arg_idx_q <= 1'b0;
      end

      // Argument words land in the state registers on the edge that pops them.
      if (pop && state_q == S_ARG) begin
        arg_idx_q <= 1'b1;
        unique case (op_q)
          OP_SETFRAME:
            if (!arg_idx_q) vram_q <= CMD_DATA;
            else begin fw_q <= CMD_DATA[31:16]; fh_q <= CMD_DATA[15:0]; end
          OP_SETDRAWAREA:
            if (!arg_idx_q) begin dax_q <= CMD_DATA[31:16]; day_q <= CMD_DATA[15:0]; end
            else            begin daw_q <= CMD_DATA[31:16]; dah_q <= CMD_DATA[15:0]; end
          OP_SETFCOLOR: color_q <= CMD_DATA;
          OP_PATBLT:
            if (!arg_idx_q) begin px_q <= CMD_DATA[31:16]; py_q <= CMD_DATA[15:0]; end
            else            begin pw_q <= CMD_DATA[31:16]; ph_q <= CMD_DATA[15:0]; end
          default: ;
        endcase
      end

      // Rectangle is frozen here, so PB_* cannot move while PB_REQ waits.
      if (state_q == S_CLIP && !clip_empty) begin
        pb_x_q <= span_x.lo[15:0];
        pb_y_q <= span_y.lo[15:0];
        pb_w_q <= span_x.hi[15:0] - span_x.lo[15:0];
        pb_h_q <= span_y.hi[15:0] - span_y.lo[15:0];
      end
    end
  end

  assign CMD_RDEN   = pop;
  assign PB_REQ     = (state_q == S_ISSUE);
  assign PB_VRAMADR = vram_q;
  assign PB_STRIDE  = fw_q;
  assign PB_X       = pb_x_q;
  assign PB_Y       = pb_y_q;
  assign PB_W       = pb_w_q;
  assign PB_H       = pb_h_q;
  assign PB_COLOR   = color_q;
  assign BUSY       = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign ERR        = err_q;
  assign ERR_OP     = err_op_q;
  assign DRW_IRQ    = (state_q == S_DONE);

endmodule

// File: tb/tb_draw_cmd_seq.sv
// tb_draw_cmd_seq -- directed self-checking bench for draw_cmd_seq.
// A small array-backed FWFT FIFO model feeds command words; a negedge
// monitor records handshakes and IRQ pulses.
module tb_draw_cmd_seq;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        START = 1'b0;
  logic [31:0] CMD_DATA = '0;
  logic        CMD_EMPTY = 1'b1;
  logic        CMD_RDEN;
  logic        PB_REQ;
  logic        PB_ACK = 1'b0;
  logic        PB_IDLE = 1'b1;
  logic [31:0] PB_VRAMADR;
  logic [15:0] PB_STRIDE, PB_X, PB_Y, PB_W, PB_H;
  logic [31:0] PB_COLOR;
  logic        BUSY, ERR, DRW_IRQ;
  logic [7:0]  ERR_OP;

  draw_cmd_seq dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START),
    .CMD_DATA(CMD_DATA), .CMD_EMPTY(CMD_EMPTY), .CMD_RDEN(CMD_RDEN),
    .PB_REQ(PB_REQ), .PB_ACK(PB_ACK), .PB_IDLE(PB_IDLE),
    .PB_VRAMADR(PB_VRAMADR), .PB_STRIDE(PB_STRIDE),
    .PB_X(PB_X), .PB_Y(PB_Y), .PB_W(PB_W), .PB_H(PB_H),
    .PB_COLOR(PB_COLOR), .BUSY(BUSY), .ERR(ERR), .ERR_OP(ERR_OP),
    .DRW_IRQ(DRW_IRQ)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_errors = 0;

  // FIFO model: mem/wr_ptr written by the stimulus, rd_ptr by the driver
  logic [31:0] mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        rden_s = 1'b0;
  logic        ack_en = 1'b1;

  // Handshake / IRQ monitor
  int          req_cnt = 0;
  int          irq_cnt = 0;
  logic [15:0] h_x, h_y, h_w, h_h, h_stride;
  logic [31:0] h_color, h_vram;

  always @(negedge ACLK) begin
    rden_s <= CMD_RDEN;
    if (PB_REQ && PB_ACK) begin
      req_cnt  <= req_cnt + 1;
      h_x      <= PB_X;
      h_y      <= PB_Y;
      h_w      <= PB_W;
      h_h      <= PB_H;
      h_stride <= PB_STRIDE;
      h_color  <= PB_COLOR;
      h_vram   <= PB_VRAMADR;
    end
    if (DRW_IRQ) irq_cnt <= irq_cnt + 1;
  end

  // Input driver, updated just after each rising edge
  always @(posedge ACLK) begin
    #1;
    if (rden_s) rd_ptr = rd_ptr + 1;
    CMD_EMPTY = (rd_ptr == wr_ptr);
    CMD_DATA  = (rd_ptr == wr_ptr) ? 32'h0 : mem[rd_ptr];
    PB_ACK    = ack_en && PB_REQ;
  end

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic cmd_frame(input logic [31:0] adr, input logic [15:0] w, h);
    push(32'h2000_0000); push(adr); push({w, h});
  endtask

  task automatic cmd_area(input logic [15:0] x, y, w, h);
    push(32'h2100_0000); push({x, y}); push({w, h});
  endtask

  task automatic cmd_color(input logic [31:0] c);
    push(32'h2300_0000); push(c);
  endtask

  task automatic cmd_pat(input logic [15:0] x, y, w, h);
    push(32'h8100_0000); push({x, y}); push({w, h});
  endtask

  // START high for one cycle; returns just after the edge that samples it
  task automatic kick;
    @(posedge ACLK); #2 START = 1'b1;
    @(posedge ACLK); #2 START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < 3000) begin
      @(negedge ACLK);
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_errors++;
      $display("FAIL %s_timeout: BUSY=%b after %0d cycles, required 0", name, BUSY, n);
    end
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_reset;
    ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);
    n_checks++;
    if ({BUSY, CMD_RDEN, PB_REQ, DRW_IRQ, ERR} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_flags: got %b, required 00000", {BUSY, CMD_RDEN, PB_REQ, DRW_IRQ, ERR});
    end
    n_checks++;
    if ({PB_X, PB_Y, PB_W, PB_H, PB_STRIDE, ERR_OP} !== 88'h0) begin
      n_errors++;
      $display("FAIL reset_fields: got %h, required 0", {PB_X, PB_Y, PB_W, PB_H, PB_STRIDE, ERR_OP});
    end
    n_checks++;
    if ({PB_VRAMADR, PB_COLOR} !== 64'h0) begin
      n_errors++;
      $display("FAIL reset_vram_color: got %h, required 0", {PB_VRAMADR, PB_COLOR});
    end
    @(posedge ACLK); #2 ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
  endtask

  task automatic test_full_fill;
    int r0 = req_cnt;
    int i0 = irq_cnt;
    cmd_frame(32'h2000_0000, 16'd640, 16'd480);
    cmd_area(16'd0, 16'd0, 16'd640, 16'd480);
    cmd_color(32'h00FF_0000);
    cmd_pat(16'd0, 16'd0, 16'd640, 16'd480);
    push(32'h0F00_0000);
    @(posedge ACLK); #2 START = 1'b1;
    @(negedge ACLK);
    n_checks++;
    if (CMD_RDEN !== 1'b0) begin
      n_errors++;
      $display("FAIL full_rden_start_cycle: got %b, required 0", CMD_RDEN);
    end
    @(posedge ACLK); #2 START = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (CMD_RDEN !== 1'b1 || BUSY !== 1'b1) begin
      n_errors++;
      $display("FAIL full_rden_next_cycle: rden=%b busy=%b, required 1 1", CMD_RDEN, BUSY);
    end
    wait_done("full");
    n_checks++;
    if (req_cnt - r0 !== 1) begin
      n_errors++;
      $display("FAIL full_req_count: got %0d, required 1", req_cnt - r0);
    end
    n_checks++;
    if ({h_x, h_y, h_w, h_h} !== {16'd0, 16'd0, 16'd640, 16'd480}) begin
      n_errors++;
      $display("FAIL full_rect: got x=%0d y=%0d w=%0d h=%0d, required 0 0 640 480", h_x, h_y, h_w, h_h);
    end
    n_checks++;
    if ({h_color, h_stride, h_vram} !== {32'h00FF_0000, 16'd640, 32'h2000_0000}) begin
      n_errors++;
      $display("FAIL full_frame_color: got color=%h stride=%0d vram=%h, required 00ff0000 640 20000000",
               h_color, h_stride, h_vram);
    end
    n_checks++;
    if (irq_cnt - i0 !== 1 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL full_irq_busy: irqs=%0d busy=%b, required 1 0", irq_cnt - i0, BUSY);
    end
  endtask

  task automatic test_area_clip;
    int r0 = req_cnt;
    cmd_area(16'd160, 16'd120, 16'd320, 16'd240);
    cmd_pat(16'd0, 16'd0, 16'd640, 16'd480);
    push(32'h0000_0000);
    push(32'h0F00_0000);
    kick();
    wait_done("area");
    n_checks++;
    if (req_cnt - r0 !== 1 || {h_x, h_y, h_w, h_h} !== {16'd160, 16'd120, 16'd320, 16'd240}) begin
      n_errors++;
      $display("FAIL area_clip: reqs=%0d x=%0d y=%0d w=%0d h=%0d, required 1 160 120 320 240",
               req_cnt - r0, h_x, h_y, h_w, h_h);
    end
  endtask

  task automatic test_edge_clip;
    int r0 = req_cnt;
    cmd_area(16'd0, 16'd0, 16'd640, 16'd480);
    cmd_pat(16'd480, 16'd360, 16'd320, 16'd240);
    push(32'h0F00_0000);
    kick();
    wait_done("edge");
    n_checks++;
    if (req_cnt - r0 !== 1 || {h_x, h_y, h_w, h_h} !== {16'd480, 16'd360, 16'd160, 16'd120}) begin
      n_errors++;
      $display("FAIL edge_clip: reqs=%0d x=%0d y=%0d w=%0d h=%0d, required 1 480 360 160 120",
               req_cnt - r0, h_x, h_y, h_w, h_h);
    end
  endtask

  task automatic test_empty;
    int r0 = req_cnt;
    int i0 = irq_cnt;
    cmd_pat(16'd700, 16'd0, 16'd10, 16'd10);
    cmd_pat(16'd0, 16'd480, 16'd10, 16'd10);
    push(32'h0F00_0000);
    kick();
    wait_done("empty");
    n_checks++;
    if (req_cnt - r0 !== 0 || irq_cnt - i0 !== 1) begin
      n_errors++;
      $display("FAIL empty_no_req: reqs=%0d irqs=%0d, required 0 1", req_cnt - r0, irq_cnt - i0);
    end
  endtask

  // Same PATBLT twice, once contiguous and once with 20-cycle FIFO gaps
  task automatic test_gaps;
    int r0;
    cmd_area(16'd160, 16'd120, 16'd320, 16'd240);
    for (int pass = 0; pass < 2; pass++) begin
      r0 = req_cnt;
      push(32'h8100_0000);
      if (pass == 0) begin
        push({16'd10, 16'd20}); push({16'd30, 16'd40}); push(32'h0F00_0000);
        kick();
      end else begin
        kick();
        repeat (20) @(negedge ACLK);
        n_checks++;
        if (BUSY !== 1'b1 || CMD_RDEN !== 1'b0 || PB_REQ !== 1'b0) begin
          n_errors++;
          $display("FAIL gap_stall: busy=%b rden=%b req=%b, required 1 0 0", BUSY, CMD_RDEN, PB_REQ);
        end
        push({16'd10, 16'd20});
        repeat (20) @(negedge ACLK);
        push({16'd30, 16'd40});
        repeat (20) @(negedge ACLK);
        push(32'h0F00_0000);
      end
      wait_done("gaps");
      n_checks++;
      if (req_cnt - r0 !== 1 || {h_x, h_y, h_w, h_h} !== {16'd170, 16'd140, 16'd30, 16'd40}) begin
        n_errors++;
        $display("FAIL gaps_rect_pass%0d: reqs=%0d x=%0d y=%0d w=%0d h=%0d, required 1 170 140 30 40",
                 pass, req_cnt - r0, h_x, h_y, h_w, h_h);
      end
    end
  endtask

  task automatic test_drain;
    int i0 = irq_cnt;
    PB_IDLE = 1'b0;
    push(32'h0F00_0000);
    kick();
    repeat (10) @(negedge ACLK);
    n_checks++;
    if (BUSY !== 1'b1 || irq_cnt !== i0) begin
      n_errors++;
      $display("FAIL drain_wait: busy=%b irqs=%0d, required 1 0", BUSY, irq_cnt - i0);
    end
    PB_IDLE = 1'b1;
    wait_done("drain");
    n_checks++;
    if (irq_cnt - i0 !== 1) begin
      n_errors++;
      $display("FAIL drain_irq: got %0d, required 1", irq_cnt - i0);
    end
  endtask

  task automatic test_ack_stall;
    int n = 0;
    ack_en = 1'b0;
    cmd_area(16'd0, 16'd0, 16'd640, 16'd480);
    cmd_pat(16'd480, 16'd360, 16'd320, 16'd240);
    push(32'h0F00_0000);
    kick();
    // header, two area args, header, two pat args, CLIP, then ISSUE
    while (PB_REQ !== 1'b1 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    n_checks++;
    if (n != 8) begin
      n_errors++;
      $display("FAIL stall_req_latency: got %0d cycles, required 8", n);
    end
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      n_checks++;
      if (PB_REQ !== 1'b1 || {PB_X, PB_Y, PB_W, PB_H, PB_STRIDE} !==
          {16'd480, 16'd360, 16'd160, 16'd120, 16'd640}) begin
        n_errors++;
        $display("FAIL stall_stable_c%0d: req=%b x=%0d y=%0d w=%0d h=%0d stride=%0d, required 1 480 360 160 120 640",
                 c, PB_REQ, PB_X, PB_Y, PB_W, PB_H, PB_STRIDE);
      end
    end
    ack_en = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    n_checks++;
    if (PB_REQ !== 1'b0) begin
      n_errors++;
      $display("FAIL stall_req_drop: got %b, required 0", PB_REQ);
    end
    wait_done("stall");
  endtask

  task automatic test_error;
    int i0 = irq_cnt;
    push(32'h5500_0000);
    kick();
    wait_done("error");
    n_checks++;
    if (ERR !== 1'b1 || ERR_OP !== 8'h55 || BUSY !== 1'b0 || irq_cnt !== i0) begin
      n_errors++;
      $display("FAIL error_flags: err=%b op=%h busy=%b irqs=%0d, required 1 55 0 0",
               ERR, ERR_OP, BUSY, irq_cnt - i0);
    end
    push(32'h0F00_0000);
    kick();
    @(negedge ACLK);
    n_checks++;
    if (ERR !== 1'b0 || ERR_OP !== 8'h00) begin
      n_errors++;
      $display("FAIL error_clear: err=%b op=%h, required 0 00", ERR, ERR_OP);
    end
    wait_done("error_clear");
    n_checks++;
    if (irq_cnt - i0 !== 1) begin
      n_errors++;
      $display("FAIL error_next_list_irq: got %0d, required 1", irq_cnt - i0);
    end
  endtask

  task automatic test_reset_in_issue;
    int n = 0;
    int i0 = irq_cnt;
    ack_en = 1'b0;
    cmd_color(32'h1234_5678);
    cmd_pat(16'd1, 16'd2, 16'd3, 16'd4);
    push(32'h0F00_0000);
    kick();
    while (PB_REQ !== 1'b1 && n < 200) begin
      @(negedge ACLK);
      n++;
    end
    n_checks++;
    if (PB_REQ !== 1'b1 || PB_COLOR !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL rst_issue_reached: req=%b color=%h, required 1 12345678", PB_REQ, PB_COLOR);
    end
    #2 ARESETN = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if ({BUSY, CMD_RDEN, PB_REQ, DRW_IRQ, ERR} !== 5'b0 ||
        {PB_X, PB_Y, PB_W, PB_H, PB_STRIDE, PB_VRAMADR, PB_COLOR} !== 144'h0) begin
      n_errors++;
      $display("FAIL rst_issue_outputs: flags=%b data=%h, required all 0",
               {BUSY, CMD_RDEN, PB_REQ, DRW_IRQ, ERR},
               {PB_X, PB_Y, PB_W, PB_H, PB_STRIDE, PB_VRAMADR, PB_COLOR});
    end
    ack_en = 1'b1;
    @(posedge ACLK); #2 ARESETN = 1'b1;
    repeat (5) @(negedge ACLK);
    n_checks++;
    if (irq_cnt !== i0 || BUSY !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_issue_no_irq: irqs=%0d busy=%b, required 0 0", irq_cnt - i0, BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_area_clip();
    test_edge_clip();
    test_empty();
    test_gaps();
    test_drain();
    test_ack_stall();
    test_error();
    test_reset_in_issue();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
